// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline registers.
package mips_pkg;

    localparam int unsigned CTRL_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Opaque EX/MEM/WB control bundle at the core's default width.
    typedef logic [CTRL_W_DEF-1:0] ctrl_t;

    // Multi-cycle MULT/DIV occupancy tracker.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_e;

    // What the ID/EX register does on the next edge.
    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,
        UPD_BUBBLE = 2'd1,
        UPD_HOLD   = 2'd2
    } id_ex_upd_e;

    // Width-independent part of the ID/EX register: validity, register
    // indices and the hazard-relevant control bits.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:    1'b0,
        rs:       REG_ZERO,
        rt:       REG_ZERO,
        rd:       REG_ZERO,
        regwrite: 1'b0,
        memread:  1'b0
    };

    // True when a real (non-$0) destination matches a source index.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose
// destination is a source of the instruction currently in ID.
module load_use_detect
    import mips_pkg::*;
(
    input  logic       dec_valid,
    input  logic [4:0] dec_rs,
    input  logic [4:0] dec_rt,
    input  logic       dec_ex_valid,
    input  logic       dec_ex_memread,
    input  logic [4:0] dec_ex_rd,
    output logic       load_use
);

    // Compare EX load destination against both ID source indices.
    always_comb begin
        load_use = dec_valid & dec_ex_valid & dec_ex_memread
                 & (reg_match(dec_ex_rd, dec_rs) | reg_match(dec_ex_rd, dec_rt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use stall, multi-cycle
// MULT/DIV hold and branch flush handling.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned CTRL_W     = CTRL_W_DEF,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [4:0]        dec_rs,
    input  logic [4:0]        dec_rt,
    input  logic [4:0]        dec_rd,
    input  logic [DATA_W-1:0] dec_rs_data,
    input  logic [DATA_W-1:0] dec_rt_data,
    input  logic [DATA_W-1:0] dec_imm,
    input  logic [CTRL_W-1:0] dec_ctrl,
    input  logic              dec_regwrite,
    input  logic              dec_memread,
    input  logic              dec_muldiv,
    input  logic              ex_flush,
    output logic              dec_ex_valid,
    output logic [4:0]        dec_ex_rs,
    output logic [4:0]        dec_ex_rt,
    output logic [4:0]        dec_ex_rd,
    output logic [DATA_W-1:0] dec_ex_rs_data,
    output logic [DATA_W-1:0] dec_ex_rt_data,
    output logic [DATA_W-1:0] dec_ex_imm,
    output logic [CTRL_W-1:0] dec_ex_ctrl,
    output logic              dec_ex_regwrite,
    output logic              dec_ex_memread,
    output logic              stall,
    output logic              muldiv_busy
);

    // The muldiv instruction itself accounts for the first EX cycle, so the
    // counter only covers the extra cycles.
    localparam logic [3:0] MD_RELOAD = 4'(MULDIV_LAT - 1);
    localparam bit         MD_MULTI  = (MULDIV_LAT > 1);

    id_ex_t              ex_q;
    logic [DATA_W-1:0]   rs_data_q;
    logic [DATA_W-1:0]   rt_data_q;
    logic [DATA_W-1:0]   imm_q;
    logic [CTRL_W-1:0]   ctrl_q;

    muldiv_state_e       state_q;
    muldiv_state_e       state_d;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;

    id_ex_upd_e          upd;
    logic                hold;
    logic                load_use;
    id_ex_t              ex_load;

    load_use_detect u_load_use_detect (
        .dec_valid      (dec_valid),
        .dec_rs         (dec_rs),
        .dec_rt         (dec_rt),
        .dec_ex_valid   (ex_q.valid),
        .dec_ex_memread (ex_q.memread),
        .dec_ex_rd      (ex_q.rd),
        .load_use       (load_use)
    );

    // Fields captured from ID on a normal load.
    always_comb begin
        ex_load          = ID_EX_BUBBLE;
        ex_load.valid    = 1'b1;
        ex_load.rs       = dec_rs;
        ex_load.rt       = dec_rt;
        ex_load.rd       = dec_rd;
        ex_load.regwrite = dec_regwrite;
        ex_load.memread  = dec_memread;
    end

    // Prioritised next-state: flush, muldiv hold, load-use bubble, normal load.
    always_comb begin
        hold    = (state_q == BUSY) && (cnt_q != 4'd0);
        stall   = ~ex_flush & (hold | load_use);
        state_d = state_q;
        cnt_d   = cnt_q;
        upd     = UPD_LOAD;

        if (ex_flush) begin
            upd     = UPD_BUBBLE;
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (hold) begin
            upd     = UPD_HOLD;
            cnt_d   = cnt_q - 4'd1;
        end else if (load_use) begin
            upd     = UPD_BUBBLE;
            state_d = IDLE;
        end else begin
            upd = dec_valid ? UPD_LOAD : UPD_BUBBLE;
            // A muldiv reaching EX right as the previous one drains re-arms
            // the counter instead of dropping to IDLE.
            if (dec_valid && dec_muldiv && MD_MULTI) begin
                state_d = BUSY;
                cnt_d   = MD_RELOAD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Muldiv FSM state and occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q      <= ID_EX_BUBBLE;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            case (upd)
                UPD_LOAD: begin
                    ex_q      <= ex_load;
                    rs_data_q <= dec_rs_data;
                    rt_data_q <= dec_rt_data;
                    imm_q     <= dec_imm;
                    ctrl_q    <= dec_ctrl;
                end
                UPD_BUBBLE: begin
                    ex_q      <= ID_EX_BUBBLE;
                    rs_data_q <= '0;
                    rt_data_q <= '0;
                    imm_q     <= '0;
                    ctrl_q    <= '0;
                end
                default: begin
                    ex_q      <= ex_q;
                    rs_data_q <= rs_data_q;
                    rt_data_q <= rt_data_q;
                    imm_q     <= imm_q;
                    ctrl_q    <= ctrl_q;
                end
            endcase
        end
    end

    // Registered outputs to EX and the bypass unit.
    always_comb begin
        dec_ex_valid    = ex_q.valid;
        dec_ex_rs       = ex_q.rs;
        dec_ex_rt       = ex_q.rt;
        dec_ex_rd       = ex_q.rd;
        dec_ex_regwrite = ex_q.regwrite;
        dec_ex_memread  = ex_q.memread;
        dec_ex_rs_data  = rs_data_q;
        dec_ex_rt_data  = rt_data_q;
        dec_ex_imm      = imm_q;
        dec_ex_ctrl     = ctrl_q;
        muldiv_busy     = (state_q == BUSY);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage with MULDIV_LAT = 4.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_rd;
    logic [31:0] dec_rs_data;
    logic [31:0] dec_rt_data;
    logic [31:0] dec_imm;
    logic [7:0]  dec_ctrl;
    logic        dec_regwrite;
    logic        dec_memread;
    logic        dec_muldiv;
    logic        ex_flush;
    logic        dec_ex_valid;
    logic [4:0]  dec_ex_rs;
    logic [4:0]  dec_ex_rt;
    logic [4:0]  dec_ex_rd;
    logic [31:0] dec_ex_rs_data;
    logic [31:0] dec_ex_rt_data;
    logic [31:0] dec_ex_imm;
    logic [7:0]  dec_ex_ctrl;
    logic        dec_ex_regwrite;
    logic        dec_ex_memread;
    logic        stall;
    logic        muldiv_busy;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.DATA_W(32), .CTRL_W(8), .MULDIV_LAT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .dec_valid       (dec_valid),
        .dec_rs          (dec_rs),
        .dec_rt          (dec_rt),
        .dec_rd          (dec_rd),
        .dec_rs_data     (dec_rs_data),
        .dec_rt_data     (dec_rt_data),
        .dec_imm         (dec_imm),
        .dec_ctrl        (dec_ctrl),
        .dec_regwrite    (dec_regwrite),
        .dec_memread     (dec_memread),
        .dec_muldiv      (dec_muldiv),
        .ex_flush        (ex_flush),
        .dec_ex_valid    (dec_ex_valid),
        .dec_ex_rs       (dec_ex_rs),
        .dec_ex_rt       (dec_ex_rt),
        .dec_ex_rd       (dec_ex_rd),
        .dec_ex_rs_data  (dec_ex_rs_data),
        .dec_ex_rt_data  (dec_ex_rt_data),
        .dec_ex_imm      (dec_ex_imm),
        .dec_ex_ctrl     (dec_ex_ctrl),
        .dec_ex_regwrite (dec_ex_regwrite),
        .dec_ex_memread  (dec_ex_memread),
        .stall           (stall),
        .muldiv_busy     (muldiv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    typedef struct {
        logic       v;
        logic [4:0] rs, rt, rd;
        logic       rw, mr, md, fl;
        logic [7:0] tag;
        logic       e_st, e_v;
        logic [4:0] e_rs, e_rt, e_rd;
        logic       e_rw, e_mr, e_busy;
        logic [7:0] e_tag;
    } vec_t;

    // Payload derived from a tag so every instruction carries distinct data;
    // tag 0 stands for a bubble (all zero).
    function automatic logic [31:0] dat(input logic [7:0] hi, input logic [7:0] tag);
        return (tag == 8'd0) ? 32'd0 : {hi, 16'h0000, tag};
    endfunction

    function automatic vec_t mk(input int v, rs, rt, rd, rw, mr, md, fl, tag,
                                input int st, ev, ers, ert, erd, erw, emr, eb, etag);
        vec_t r;
        r.v = 1'(v);   r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.rw = 1'(rw); r.mr = 1'(mr); r.md = 1'(md); r.fl = 1'(fl); r.tag = 8'(tag);
        r.e_st = 1'(st); r.e_v = 1'(ev); r.e_rs = 5'(ers); r.e_rt = 5'(ert);
        r.e_rd = 5'(erd); r.e_rw = 1'(erw); r.e_mr = 1'(emr); r.e_busy = 1'(eb);
        r.e_tag = 8'(etag);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_ex(input string pfx, input logic ev, input logic [4:0] rs, rt, rd,
                            input logic rw, mr, busy, input logic [7:0] tag);
        check({pfx, ".valid"},    32'(dec_ex_valid),    32'(ev));
        check({pfx, ".rs"},       32'(dec_ex_rs),       32'(rs));
        check({pfx, ".rt"},       32'(dec_ex_rt),       32'(rt));
        check({pfx, ".rd"},       32'(dec_ex_rd),       32'(rd));
        check({pfx, ".regwrite"}, 32'(dec_ex_regwrite), 32'(rw));
        check({pfx, ".memread"},  32'(dec_ex_memread),  32'(mr));
        check({pfx, ".busy"},     32'(muldiv_busy),     32'(busy));
        check({pfx, ".rs_data"},  dec_ex_rs_data,       dat(8'hA1, tag));
        check({pfx, ".rt_data"},  dec_ex_rt_data,       dat(8'hB2, tag));
        check({pfx, ".imm"},      dec_ex_imm,           dat(8'hC3, tag));
        check({pfx, ".ctrl"},     32'(dec_ex_ctrl),     32'(tag));
    endtask

    task automatic drive(input vec_t r);
        dec_valid    = r.v;
        dec_rs       = r.rs;
        dec_rt       = r.rt;
        dec_rd       = r.rd;
        dec_regwrite = r.rw;
        dec_memread  = r.mr;
        dec_muldiv   = r.md;
        ex_flush     = r.fl;
        dec_rs_data  = dat(8'hA1, r.tag);
        dec_rt_data  = dat(8'hB2, r.tag);
        dec_imm      = dat(8'hC3, r.tag);
        dec_ctrl     = r.tag;
    endtask

    vec_t vecs[21];

    initial begin
        //               v rs rt rd rw mr md fl tag  | st ev ers ert erd rw mr bz etag
        vecs[0]  = mk(1, 1, 2, 5, 1, 1, 0, 0, 8'h01,  0, 1, 1, 2, 5, 1, 1, 0, 8'h01); // lw r5
        vecs[1]  = mk(1, 5, 3, 6, 1, 0, 0, 0, 8'h02,  1, 0, 0, 0, 0, 0, 0, 0, 8'h00); // add uses r5: stall
        vecs[2]  = mk(1, 5, 3, 6, 1, 0, 0, 0, 8'h02,  0, 1, 5, 3, 6, 1, 0, 0, 8'h02); // retried add loads
        vecs[3]  = mk(1, 7, 0, 0, 1, 1, 0, 0, 8'h03,  0, 1, 7, 0, 0, 1, 1, 0, 8'h03); // lw r0
        vecs[4]  = mk(1, 0, 0, 8, 1, 0, 0, 0, 8'h04,  0, 1, 0, 0, 8, 1, 0, 0, 8'h04); // rs=rt=0: no hazard
        vecs[5]  = mk(1, 1, 1, 9, 1, 1, 0, 0, 8'h05,  0, 1, 1, 1, 9, 1, 1, 0, 8'h05); // lw r9
        vecs[6]  = mk(1, 2, 9, 4, 1, 0, 0, 1, 8'h06,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00); // hazard on rt + flush
        vecs[7]  = mk(0, 3, 4, 5, 1, 1, 0, 0, 8'h07,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00); // invalid ID -> bubble
        vecs[8]  = mk(1,10,11, 0, 0, 0, 1, 0, 8'h08,  0, 1,10,11, 0, 0, 0, 1, 8'h08); // MULT enters EX
        vecs[9]  = mk(1,12,13,14, 1, 0, 0, 0, 8'h09,  1, 1,10,11, 0, 0, 0, 1, 8'h08); // hold 1
        vecs[10] = mk(1,12,13,14, 1, 0, 0, 0, 8'h09,  1, 1,10,11, 0, 0, 0, 1, 8'h08); // hold 2
        vecs[11] = mk(1,12,13,14, 1, 0, 0, 0, 8'h09,  1, 1,10,11, 0, 0, 0, 1, 8'h08); // hold 3
        vecs[12] = mk(1,12,13,14, 1, 0, 0, 0, 8'h09,  0, 1,12,13,14, 1, 0, 0, 8'h09); // add loads
        vecs[13] = mk(1, 1, 2, 0, 0, 0, 1, 0, 8'h0A,  0, 1, 1, 2, 0, 0, 0, 1, 8'h0A); // MULT
        vecs[14] = mk(1, 3, 4, 0, 0, 0, 1, 0, 8'h0B,  1, 1, 1, 2, 0, 0, 0, 1, 8'h0A); // DIV waits
        vecs[15] = mk(1, 3, 4, 0, 0, 0, 1, 0, 8'h0B,  1, 1, 1, 2, 0, 0, 0, 1, 8'h0A);
        vecs[16] = mk(1, 3, 4, 0, 0, 0, 1, 0, 8'h0B,  1, 1, 1, 2, 0, 0, 0, 1, 8'h0A);
        vecs[17] = mk(1, 3, 4, 0, 0, 0, 1, 0, 8'h0B,  0, 1, 3, 4, 0, 0, 0, 1, 8'h0B); // DIV re-enters BUSY
        vecs[18] = mk(1, 5, 6, 7, 1, 0, 0, 0, 8'h0C,  1, 1, 3, 4, 0, 0, 0, 1, 8'h0B); // cnt 3 -> 2
        vecs[19] = mk(1, 5, 6, 7, 1, 0, 0, 1, 8'h0C,  0, 0, 0, 0, 0, 0, 0, 0, 8'h00); // flush at cnt 2
        vecs[20] = mk(1, 5, 6, 7, 1, 0, 0, 0, 8'h0C,  0, 1, 5, 6, 7, 1, 0, 0, 8'h0C); // add loads

        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        check("reset.stall", 32'(stall), 32'd0);
        check_ex("reset", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        #9 reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i]);
            #2;
            check($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].e_st));
            @(posedge clk); #1;
            check_ex($sformatf("v%0d", i), vecs[i].e_v, vecs[i].e_rs, vecs[i].e_rt, vecs[i].e_rd,
                     vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_busy, vecs[i].e_tag);
        end

        // Asynchronous reset with a valid add in EX: clears without a clock edge.
        drive(mk(1, 10, 11, 0, 0, 0, 1, 0, 8'h0D,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 reset = 1'b1;
        #1;
        check("rst1.stall", 32'(stall), 32'd0);
        check_ex("rst1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        check_ex("rst1.mult", 1'b1, 5'd10, 5'd11, 5'd0, 1'b0, 1'b0, 1'b1, 8'h0D);

        // Asynchronous reset while the MULT holds EX and stalls ID.
        drive(mk(1, 12, 13, 14, 1, 0, 0, 0, 8'h0E,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("rst2.pre_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check("rst2.stall", 32'(stall), 32'd0);
        check_ex("rst2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        check_ex("rst2.add", 1'b1, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 1'b0, 8'h0E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
